ext_bus_ctrl: RTL and testbench

EXT_BUS_CTRL -- requirements
Module: ext_bus_ctrl

---
 rtl/ext_bus_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ext_bus_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_ctrl.sv
// External multiplexed address/data bus controller.
// One request at a time: address phases, optional turnaround, data, recovery.
module ext_bus_ctrl #(
    parameter int DW   = 16,
    parameter int AW   = 32,
    parameter int WAIT = 1,
    localparam int NALE = AW / DW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_be,
    output logic              resp_valid,
    output logic [DW-1:0]     resp_rdata,
    input  logic [DW-1:0]     io_in,
    output logic [DW-1:0]     io_out,
    output logic              io_oe,
    output logic              oe_n,
    output logic              we_n,
    output logic [NALE-1:0]   ale,
    output logic [DW/8-1:0]   be_n
);

    typedef enum logic [2:0] {
        IDLE,
        ALE_HI,
        ALE_HOLD,
        TURN,
        DATA,
        RECOV
    } state_t;

    localparam int PW = (NALE > 1) ? $clog2(NALE) : 1;
    localparam logic [PW-1:0] LAST_PH = PW'(NALE - 1);
    localparam logic [3:0] LAST_WT = 4'(WAIT);

    state_t state;
    state_t state_nx;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;
    logic [3:0]    wcnt;
    logic [3:0]    wcnt_nx;

    logic                      we_q;
    logic [NALE-1:0][DW-1:0]   addr_q;
    logic [DW-1:0]             wdata_q;
    logic [DW/8-1:0]           be_q;
    logic [DW-1:0]             rdata_q;

    logic accept;
    logic capture;

    assign accept     = req_valid & req_ready;
    assign resp_rdata = rdata_q;

    // State register with phase and wait-state counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Request capture on accept and read data capture at end of DATA.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (capture) begin
                rdata_q <= io_in;
            end
        end
    end

    // Next-state sequencing through address, turnaround, data and recovery.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        wcnt_nx  = wcnt;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = ALE_HI;
                    phase_nx = '0;
                    wcnt_nx  = '0;
                end
            end
            ALE_HI: begin
                state_nx = ALE_HOLD;
            end
            ALE_HOLD: begin
                if (phase == LAST_PH) begin
                    state_nx = we_q ? DATA : TURN;
                end else begin
                    phase_nx = phase + 1'b1;
                    state_nx = ALE_HI;
                end
            end
            TURN: begin
                state_nx = DATA;
            end
            DATA: begin
                if (wcnt == LAST_WT) begin
                    state_nx = RECOV;
                    capture  = ~we_q;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            RECOV: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus strobes and drive values decoded from the current state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        io_out     = '0;
        io_oe      = 1'b0;
        oe_n       = 1'b1;
        we_n       = 1'b1;
        ale        = '0;
        be_n       = '1;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            ALE_HI: begin
                ale    = NALE'(1) << phase;
                io_out = addr_q[phase];
                io_oe  = 1'b1;
                be_n   = ~be_q;
            end
            ALE_HOLD: begin
                io_out = addr_q[phase];
                io_oe  = 1'b1;
                be_n   = ~be_q;
            end
            TURN: begin
                be_n = ~be_q;
            end
            DATA: begin
                be_n = ~be_q;
                if (we_q) begin
                    we_n   = 1'b0;
                    io_oe  = 1'b1;
                    io_out = wdata_q;
                end else begin
                    oe_n = 1'b0;
                end
            end
            RECOV: begin
                be_n       = ~be_q;
                resp_valid = 1'b1;
                if (we_q) begin
                    io_oe  = 1'b1;
                    io_out = wdata_q;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Self-checking bench for ext_bus_ctrl: directed and randomized
// transactions against a cycle-indexed timing model.
module tb_ext_bus_ctrl;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int WT = 1;
    localparam int N  = AW / DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic        io_oe;
    logic        oe_n;
    logic        we_n;
    logic [1:0]  ale;
    logic [1:0]  be_n;

    logic        b_req_valid;
    logic        b_req_ready;
    logic        b_req_we;
    logic [15:0] b_req_addr;
    logic [7:0]  b_req_wdata;
    logic [0:0]  b_req_be;
    logic        b_resp_valid;
    logic [7:0]  b_resp_rdata;
    logic [7:0]  b_io_in;
    logic [7:0]  b_io_out;
    logic        b_io_oe;
    logic        b_oe_n;
    logic        b_we_n;
    logic [1:0]  b_ale;
    logic [0:0]  b_be_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] rdata_m;
    logic        nxt_we;
    logic [31:0] nxt_addr;
    logic [15:0] nxt_wdata;
    logic [1:0]  nxt_be;

    ext_bus_ctrl #(.DW(DW), .AW(AW), .WAIT(WT)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .oe_n       (oe_n),
        .we_n       (we_n),
        .ale        (ale),
        .be_n       (be_n)
    );

    ext_bus_ctrl #(.DW(8), .AW(16), .WAIT(3)) u_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_we     (b_req_we),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_be     (b_req_be),
        .resp_valid (b_resp_valid),
        .resp_rdata (b_resp_rdata),
        .io_in      (b_io_in),
        .io_out     (b_io_out),
        .io_oe      (b_io_oe),
        .oe_n       (b_oe_n),
        .we_n       (b_we_n),
        .ale        (b_ale),
        .be_n       (b_be_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".ready"}, req_ready, 1);
        chk({tag, ".resp_valid"}, resp_valid, 0);
        chk({tag, ".io_oe"}, io_oe, 0);
        chk({tag, ".oe_n"}, oe_n, 1);
        chk({tag, ".we_n"}, we_n, 1);
        chk({tag, ".ale"}, ale, 0);
        chk({tag, ".be_n"}, be_n, 2'b11);
        chk({tag, ".io_out"}, io_out, 0);
        chk({tag, ".rdata"}, resp_rdata, rdata_m);
    endtask

    // One full transaction; cycle c counts edges after the accept edge.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be,
                           input logic [15:0] rdat, input bit keep);
        int lat;
        int d0;
        int k;
        bit hi;
        logic [1:0] nbe;
        nbe = ~be;
        lat = 2 * N + WT + (we ? 2 : 3);
        d0  = 2 * N + (we ? 1 : 2);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        io_in     = 16'($urandom);
        step();
        if (keep) begin
            req_we    = nxt_we;
            req_addr  = nxt_addr;
            req_wdata = nxt_wdata;
            req_be    = nxt_be;
        end else begin
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom);
        end
        for (int c = 1; c <= lat; c++) begin
            chk("busy.ready", req_ready, 0);
            chk("resp_valid", resp_valid, (c == lat));
            chk("be_n", be_n, nbe);
            if (c <= 2 * N) begin
                k  = (c - 1) / 2;
                hi = ((c - 1) % 2) == 0;
                chk("ale", ale, hi ? (1 << k) : 0);
                chk("addr_out", io_out, (addr >> (16 * k)) & 32'hFFFF);
                chk("ale.io_oe", io_oe, 1);
                chk("ale.oe_n", oe_n, 1);
                chk("ale.we_n", we_n, 1);
                chk("ale.rdata", resp_rdata, rdata_m);
            end else if (c < d0) begin
                chk("turn.ale", ale, 0);
                chk("turn.io_oe", io_oe, 0);
                chk("turn.oe_n", oe_n, 1);
                chk("turn.we_n", we_n, 1);
            end else if (c < lat) begin
                chk("data.ale", ale, 0);
                chk("data.rdata", resp_rdata, rdata_m);
                if (we) begin
                    chk("wdata.we_n", we_n, 0);
                    chk("wdata.oe_n", oe_n, 1);
                    chk("wdata.io_oe", io_oe, 1);
                    chk("wdata.io_out", io_out, wdata);
                end else begin
                    chk("rdata.oe_n", oe_n, 0);
                    chk("rdata.we_n", we_n, 1);
                    chk("rdata.io_oe", io_oe, 0);
                end
            end else begin
                chk("recov.ale", ale, 0);
                chk("recov.oe_n", oe_n, 1);
                chk("recov.we_n", we_n, 1);
                chk("recov.io_oe", io_oe, we);
                if (we) begin
                    chk("recov.io_out", io_out, wdata);
                end
                chk("recov.rdata", resp_rdata, we ? rdata_m : rdat);
            end
            if (c >= d0 && c < lat) begin
                io_in = rdat;
            end else begin
                io_in = rdat ^ 16'($urandom_range(1, 65535));
            end
            step();
        end
        if (!we) begin
            rdata_m = rdat;
        end
        idle_chk("post");
    endtask

    // Bus safety rules checked on every cycle for both instances.
    always @(negedge clk) begin
        chk("mutex", (oe_n === 1'b0 && we_n === 1'b0), 0);
        chk("oe_vs_drive", (oe_n === 1'b0 && io_oe === 1'b1), 0);
        chk("b.mutex", (b_oe_n === 1'b0 && b_we_n === 1'b0), 0);
        chk("b.oe_vs_drive", (b_oe_n === 1'b0 && b_io_oe === 1'b1), 0);
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic        cw;
        logic [31:0] ca;
        logic [15:0] cd;
        logic [1:0]  cb;
        bit          kf;
        bit          pend;
        int          olow;

        reset_n     = 1'b0;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        io_in       = '0;
        b_req_valid = 1'b0;
        b_req_we    = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        b_req_be    = '0;
        b_io_in     = '0;
        rdata_m     = '0;
        nxt_we      = 1'b0;
        nxt_addr    = '0;
        nxt_wdata   = '0;
        nxt_be      = '0;
        pend        = 1'b0;

        repeat (3) step();
        idle_chk("reset");
        chk("b.reset.ready", b_req_ready, 1);
        chk("b.reset.ale", b_ale, 0);
        chk("b.reset.be_n", b_be_n, 1);
        chk("b.reset.rdata", b_resp_rdata, 0);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        step();
        idle_chk("release");

        run_txn(1'b0, 32'h1234_5678, 16'h0000, 2'b11, 16'hBEEF, 1'b0);
        run_txn(1'b1, 32'h0000_0010, 16'hA55A, 2'b01, 16'h0000, 1'b0);

        nxt_we    = 1'b0;
        nxt_addr  = 32'hCAFE_0004;
        nxt_wdata = 16'h5151;
        nxt_be    = 2'b10;
        run_txn(1'b1, 32'h8000_0002, 16'h1357, 2'b11, 16'h0000, 1'b1);
        run_txn(nxt_we, nxt_addr, nxt_wdata, nxt_be, 16'h2468, 1'b0);

        for (int i = 0; i < 24; i++) begin
            if (!pend) begin
                nxt_we    = 1'($urandom);
                nxt_addr  = $urandom;
                nxt_wdata = 16'($urandom);
                nxt_be    = 2'($urandom);
            end
            cw = nxt_we;
            ca = nxt_addr;
            cd = nxt_wdata;
            cb = nxt_be;
            kf = ($urandom_range(0, 3) == 0);
            if (kf) begin
                nxt_we    = 1'($urandom);
                nxt_addr  = $urandom;
                nxt_wdata = 16'($urandom);
                nxt_be    = 2'($urandom);
            end
            run_txn(cw, ca, cd, cb, 16'($urandom), kf);
            pend = kf;
            if (!kf) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    idle_chk("gap");
                end
            end
        end
        if (pend) begin
            run_txn(nxt_we, nxt_addr, nxt_wdata, nxt_be, 16'h0F0F, 1'b0);
        end

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 16'hA55A;
        req_be    = 2'b01;
        step();
        req_valid = 1'b0;
        repeat (2 * N) step();
        chk("abort.pre_we_n", we_n, 0);
        reset_n = 1'b0;
        step();
        rdata_m = '0;
        chk("abort.we_n", we_n, 1);
        chk("abort.io_oe", io_oe, 0);
        chk("abort.ale", ale, 0);
        chk("abort.ready", req_ready, 1);
        chk("abort.resp_valid", resp_valid, 0);
        chk("abort.rdata", resp_rdata, 0);
        reset_n = 1'b1;
        repeat (4) begin
            step();
            idle_chk("abort.after");
        end

        olow        = 0;
        b_req_valid = 1'b1;
        b_req_we    = 1'b0;
        b_req_addr  = 16'hA5C3;
        b_req_be    = 1'b1;
        step();
        b_req_valid = 1'b0;
        b_req_addr  = 16'h0000;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 4) begin
                chk("b.ale", b_ale, (c == 1) ? 1 : ((c == 3) ? 2 : 0));
                chk("b.addr_out", b_io_out, (c <= 2) ? 8'hC3 : 8'hA5);
            end
            if (b_oe_n === 1'b0) begin
                olow++;
            end
            chk("b.resp_valid", b_resp_valid, (c == 10));
            if (c == 10) begin
                chk("b.rdata", b_resp_rdata, 8'h7E);
            end
            if (c >= 6 && c <= 9) begin
                b_io_in = 8'h7E;
            end else begin
                b_io_in = 8'h7E ^ 8'($urandom_range(1, 255));
            end
            step();
        end
        chk("b.oe_low_cycles", olow, 4);
        chk("b.post.ready", b_req_ready, 1);
        chk("b.post.resp_valid", b_resp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
